// File: rtl/inst_queue.sv
// inst_queue: fetch-to-decode instruction FIFO with immediate pre-split and flush
module inst_queue #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_inst,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic [15:0] out_imm,
    output logic        out_imm_sext,
    output logic        out_adel
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LP_FULL = (AW + 1)'(DEPTH);
    logic [63:0]   r_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [AW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;
    logic [5:0]    w_op;
    // Handshake flags depend only on occupancy, so no combinational path crosses the queue
    always_comb begin
        in_ready     = (r_cnt != LP_FULL);
        out_valid    = (r_cnt != '0);
        w_push       = in_valid && in_ready;
        w_pop        = out_valid && out_ready;
        out_pc       = r_mem[r_rd][63:32];
        out_inst     = r_mem[r_rd][31:0];
        out_imm      = out_inst[15:0];
        w_op         = out_inst[31:26];
        out_imm_sext = !((w_op == 6'h0C) || (w_op == 6'h0D) || (w_op == 6'h0E));
        out_adel     = |out_pc[1:0];
    end
    // Storage: cleared only by reset; a push coinciding with flush is dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push && !flush) begin
            r_mem[r_wr] <= {in_pc, in_inst};
        end
    end
    // Pointers and occupancy; flush overrides any simultaneous push or pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else if (flush) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop) r_rd <= r_rd + AW'(1);
            if (w_push != w_pop) r_cnt <= w_push ? r_cnt + (AW + 1)'(1) : r_cnt - (AW + 1)'(1);
        end
    end
endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: randomized scoreboard bench for inst_queue against a queue model
module tb_inst_queue;
    localparam int DEPTH = 2;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;
    logic        clk = 0;
    logic        rst = 1;
    logic        flush = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic [31:0] in_pc = 0;
    logic [31:0] in_inst = 0;
    logic        out_valid;
    logic        out_ready = 0;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [15:0] out_imm;
    logic        out_imm_sext;
    logic        out_adel;
    ent_t        q[$];
    int          checks = 0;
    int          failures = 0;
    inst_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .out_imm(out_imm), .out_imm_sext(out_imm_sext), .out_adel(out_adel)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic logic exp_sext(input logic [31:0] inst);
        int op;
        op = int'(inst[31:26]);
        return !(op == 12 || op == 13 || op == 14);
    endfunction
    // Monitor: compares the head against the oldest model entry and retires it on a pop
    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
            chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                chk("out_pc", out_pc, q[0].pc);
                chk("out_inst", out_inst, q[0].inst);
                chk("out_imm", 32'(out_imm), {16'h0, q[0].inst[15:0]});
                chk("out_imm_sext", 32'(out_imm_sext), 32'(exp_sext(q[0].inst)));
                chk("out_adel", 32'(out_adel), 32'(q[0].pc[1:0] != 2'b00));
                if (out_ready && !flush) void'(q.pop_front());
            end
        end
    end
    task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic ordy, input logic fl);
        bit acc;
        @(posedge clk);
        #1;
        in_valid  = v;
        in_pc     = pc;
        in_inst   = inst;
        out_ready = ordy;
        flush     = fl;
        acc = v && !fl && (q.size() < DEPTH);
        @(negedge clk);
        #1;
        if (fl) q.delete();
        else if (acc) q.push_back('{pc, inst});
    endtask
    task automatic reset_checks();
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst out_pc", out_pc, 32'd0);
        chk("rst out_inst", out_inst, 32'd0);
        chk("rst out_imm", 32'(out_imm), 32'd0);
        chk("rst out_imm_sext", 32'(out_imm_sext), 32'd1);
        chk("rst out_adel", 32'(out_adel), 32'd0);
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
    initial begin
        logic [31:0] pc, inst;
        repeat (2) @(posedge clk);
        #1;
        reset_checks();
        @(negedge clk);
        rst = 0;
        // streaming
        for (int i = 0; i < 3; i++) cyc(1, 32'h0040_0000 + 32'(4 * i), $urandom, 1, 0);
        repeat (2) cyc(0, 0, 0, 1, 0);
        // full / backpressure
        cyc(1, 32'h0040_0100, 32'h2008_000A, 0, 0);
        cyc(1, 32'h0040_0104, 32'h3408_FFFF, 0, 0);
        cyc(1, 32'h0040_0108, 32'hDEAD_BEEF, 0, 0);
        chk("full in_ready", 32'(in_ready), 32'd0);
        chk("full imm", 32'(out_imm), 32'h000A);
        chk("full sext", 32'(out_imm_sext), 32'd1);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        chk("pop imm", 32'(out_imm), 32'hFFFF);
        chk("pop sext", 32'(out_imm_sext), 32'd0);
        chk("pop in_ready", 32'(in_ready), 32'd1);
        repeat (2) cyc(0, 0, 0, 1, 0);
        // flush with simultaneous push and pop
        cyc(1, 32'h0040_0200, $urandom, 0, 0);
        cyc(1, 32'h0040_0204, $urandom, 0, 0);
        cyc(1, 32'h0040_0208, 32'h1234_5678, 1, 1);
        cyc(0, 0, 0, 0, 0);
        chk("flush out_valid", 32'(out_valid), 32'd0);
        chk("flush in_ready", 32'(in_ready), 32'd1);
        // misaligned PC
        cyc(1, 32'h0040_0002, 32'h3C01_ABCD, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("adel", 32'(out_adel), 32'd1);
        chk("adel inst", out_inst, 32'h3C01_ABCD);
        repeat (2) cyc(0, 0, 0, 1, 0);
        // randomized traffic including pointer wrap and occasional flush
        for (int i = 0; i < 400; i++) begin
            pc = $urandom;
            if ($urandom_range(3) != 0) pc[1:0] = 2'b00;
            inst = $urandom;
            if ($urandom_range(2) == 0) inst[31:26] = 6'(12 + $urandom_range(2));
            cyc($urandom_range(3) != 0, pc, inst, $urandom_range(2) != 0, $urandom_range(29) == 0);
        end
        repeat (3) cyc(0, 0, 0, 1, 0);
        // asynchronous reset with two entries held
        cyc(1, 32'h0040_0300, 32'h2002_0001, 0, 0);
        cyc(1, 32'h0040_0304, 32'h2002_0002, 0, 0);
        cyc(0, 0, 0, 0, 0);
        in_valid = 0;
        #2 rst = 1;
        #1;
        reset_checks();
        q.delete();
        @(posedge clk);
        @(negedge clk);
        #2 rst = 0;
        repeat (2) cyc(0, 0, 0, 1, 0);
        chk("post-rst out_valid", 32'(out_valid), 32'd0);
        cyc(1, 32'h0040_0400, $urandom, 1, 0);
        repeat (2) cyc(0, 0, 0, 1, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
